multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset.
REQ-003 OpCode  input  6  IR[31:26]; IR is stable from ID onward.
REQ-004 Funct  input  6  IR[5:0].
REQ-005 MemReady  input  1  memory handshake; 1 = access completes this cycle.
REQ-006 PCWrite / PCWriteCond  output  1 each  unconditional and branch-conditional PC write enables.
REQ-007 IorD  output  1  memory address source: 0 = PC, 1 = ALUOut.
REQ-008 MemRead / MemWrite / IRWrite / RegWrite  output  1 each  strobes.
REQ-009 RegDst  output  2  register write address: 00 = rt, 01 = rd, 10 = $31.
REQ-010 MemtoReg  output  2  write-back data: 00 = ALUOut, 01 = MDR, 10 = PC.
REQ-011 ALUSrcA  output  2  ALU A input: 00 = PC, 01 = regA, 10 = shamt.
REQ-012 ALUSrcB  output  2  ALU B input: 00 = regB, 01 = 4, 10 = ext imm, 11 = sext imm<<2.
REQ-013 ALUOp  output  4  [2:0]: 000 add, 001 sub, 100 and, 101 slt, 010 R-type (funct decode); [3] = 1 unsigned.
REQ-014 PCSource  output  2  next PC: 00 = ALU, 01 = ALUOut, 10 = jump target, 11 = regA.
REQ-015 ExtOp / LuiOp  output  1 each  1 = sign-extend imm; 1 = imm<<16.
REQ-016 State  output  3  current FSM state: IF=0, ID=1, EX=2, MEM=3, WB=4.

Function
REQ-017 The FSM SHALL be Moore, with outputs decoded combinationally from State, OpCode and Funct; any output not listed for a state SHALL be 0.
REQ-018 IF: MemRead=1, IorD=0, IRWrite=1, ALUSrcA=00, ALUSrcB=01, ALUOp=add, PCSource=00, PCWrite=1; IF -> ID.
REQ-019 ID: ALUSrcA=00, ALUSrcB=11, ALUOp=add, ExtOp=1 (branch target into ALUOut).
REQ-020 ID with j (02): PCSource=10, PCWrite=1; ID -> IF.
REQ-021 ID with jal (03): as j, plus RegWrite=1, RegDst=10, MemtoReg=10; ID -> IF.
REQ-022 ID with R-type jr (08) or jalr (09): PCSource=11, PCWrite=1; jalr also RegWrite=1, RegDst=01, MemtoReg=10; ID -> IF.
REQ-023 ID with an unsupported opcode: no strobes asserted (NOP); ID -> IF.
REQ-024 ID with any other supported opcode: ID -> EX.
REQ-025 EX R-type: ALUSrcA=10 for funct 00/02/03, otherwise 01; ALUSrcB=00; ALUOp=0010; EX -> WB.
REQ-026 EX addi/addiu/slti/sltiu/andi/lui: ALUSrcA=01, ALUSrcB=10, ALUOp = add/add(ALUOp[3]=1)/slt/slt(ALUOp[3]=1)/and/add; ExtOp=0 for andi only; LuiOp=1 for lui only; EX -> WB.
REQ-027 EX lw/sw: ALUSrcA=01, ALUSrcB=10, ExtOp=1, ALUOp=add; EX -> MEM.
REQ-028 EX beq (04): ALUSrcA=01, ALUSrcB=00, ALUOp=sub, PCWriteCond=1, PCSource=01; EX -> IF.
REQ-029 MEM: IorD=1; lw: MemRead=1, MEM -> WB; sw: MemWrite=1, MEM -> IF.
REQ-030 WB: RegWrite=1; RegDst=01 for R-type, otherwise 00; MemtoReg=01 for lw, otherwise 00; WB -> IF.
REQ-031 Cycles per instruction without stalls: j/jal/jr/jalr/NOP 2, beq 3, R/I-ALU 4, sw 4, lw 5.

Reset
REQ-032 While reset=0, State SHALL be IF and PCWrite, PCWriteCond, IRWrite, RegWrite, MemWrite SHALL be forced to 0.
REQ-033 Reset asserted mid-instruction SHALL abort it immediately; the first rising edge after release SHALL execute IF.

Configuration
REQ-034 With MEM_WAIT_EN defined, IF and MEM SHALL hold state while MemReady=0, suppressing PCWrite, IRWrite and MemWrite, which SHALL assert only in the cycle in which MemReady=1.
REQ-035 Without MEM_WAIT_EN, MemReady SHALL be ignored and every memory access SHALL complete in one cycle.

Verification
REQ-036 addu (OpCode 00, Funct 21) -> State 0,1,2,4,0; ALUOp=0010 in EX; RegWrite=1 and RegDst=01 in WB.
REQ-037 lw (23) -> 5 cycles; IorD=1 and MemRead=1 in MEM; MemtoReg=01 in WB.
REQ-038 beq (04) -> EX: ALUOp=0001, PCWriteCond=1, PCSource=01; next State=0.
REQ-039 jal (03) -> ID: PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=10; 2 cycles.
REQ-040 MEM_WAIT_EN with lw and MemReady=0 for 3 cycles in MEM -> State stays 3 for 4 cycles, then goes to 4.
REQ-041 reset=0 asserted during EX of sw -> State=0 immediately; MemWrite never asserts.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore control FSM for a five-state (IF/ID/EX/MEM/WB)
// multicycle MIPS-style datapath. Outputs are decoded combinationally from
// the current state and the instruction fields.
// Optional build macro: MEM_WAIT_EN -- IF and MEM stall on MemReady=0.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OpCode,
    input  logic [5:0] Funct,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       ExtOp,
    output logic       LuiOp,
    output logic [2:0] State
);

    localparam int unsigned ST_W  = 3;
    localparam int unsigned OP_W  = 6;
    localparam int unsigned ALU_W = 4;

    localparam logic [ST_W-1:0] S_IF  = ST_W'(0);
    localparam logic [ST_W-1:0] S_ID  = ST_W'(1);
    localparam logic [ST_W-1:0] S_EX  = ST_W'(2);
    localparam logic [ST_W-1:0] S_MEM = ST_W'(3);
    localparam logic [ST_W-1:0] S_WB  = ST_W'(4);

    localparam logic [OP_W-1:0] OP_R     = OP_W'(6'h00);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(6'h02);
    localparam logic [OP_W-1:0] OP_JAL   = OP_W'(6'h03);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'h04);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'h08);
    localparam logic [OP_W-1:0] OP_ADDIU = OP_W'(6'h09);
    localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(6'h0A);
    localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(6'h0B);
    localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(6'h0C);
    localparam logic [OP_W-1:0] OP_LUI   = OP_W'(6'h0F);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'h23);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'h2B);

    localparam logic [OP_W-1:0] FN_SLL  = OP_W'(6'h00);
    localparam logic [OP_W-1:0] FN_SRL  = OP_W'(6'h02);
    localparam logic [OP_W-1:0] FN_SRA  = OP_W'(6'h03);
    localparam logic [OP_W-1:0] FN_JR   = OP_W'(6'h08);
    localparam logic [OP_W-1:0] FN_JALR = OP_W'(6'h09);

    localparam logic [ALU_W-1:0] ALU_ADD   = ALU_W'(4'b0000);
    localparam logic [ALU_W-1:0] ALU_SUB   = ALU_W'(4'b0001);
    localparam logic [ALU_W-1:0] ALU_RTYPE = ALU_W'(4'b0010);
    localparam logic [ALU_W-1:0] ALU_AND   = ALU_W'(4'b0100);
    localparam logic [ALU_W-1:0] ALU_SLT   = ALU_W'(4'b0101);
    localparam logic [ALU_W-1:0] ALU_ADDU  = ALU_W'(4'b1000);
    localparam logic [ALU_W-1:0] ALU_SLTU  = ALU_W'(4'b1101);

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_REG   = 2'b01;
    localparam logic [1:0] SRCA_SHAMT = 2'b10;
    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BR    = 2'b11;
    localparam logic [1:0] DST_RT     = 2'b00;
    localparam logic [1:0] DST_RD     = 2'b01;
    localparam logic [1:0] DST_RA     = 2'b10;
    localparam logic [1:0] WB_ALUOUT  = 2'b00;
    localparam logic [1:0] WB_MDR     = 2'b01;
    localparam logic [1:0] WB_PC      = 2'b10;
    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_REGA   = 2'b11;

    logic [ST_W-1:0]  state;
    logic [ST_W-1:0]  next_state;
    logic             mem_ok;
    logic             is_r, is_j, is_jal, is_jr, is_jalr, is_beq;
    logic             is_lw, is_sw, is_andi, is_lui, is_alu_imm, is_shift;
    logic             is_jump, supported;
    logic [ALU_W-1:0] imm_alu_op;

`ifdef MEM_WAIT_EN
    assign mem_ok = MemReady;
`else
    // Every memory access completes in one cycle; the handshake is ignored.
    logic unused_mem_ready;
    assign unused_mem_ready = MemReady;
    assign mem_ok           = 1'b1;
`endif

    assign State = state;

    // Instruction class decode from the (stable) instruction register fields.
    assign is_r       = (OpCode == OP_R);
    assign is_j       = (OpCode == OP_J);
    assign is_jal     = (OpCode == OP_JAL);
    assign is_jr      = is_r && (Funct == FN_JR);
    assign is_jalr    = is_r && (Funct == FN_JALR);
    assign is_beq     = (OpCode == OP_BEQ);
    assign is_lw      = (OpCode == OP_LW);
    assign is_sw      = (OpCode == OP_SW);
    assign is_andi    = (OpCode == OP_ANDI);
    assign is_lui     = (OpCode == OP_LUI);
    assign is_alu_imm = (OpCode == OP_ADDI) || (OpCode == OP_ADDIU) ||
                        (OpCode == OP_SLTI) || (OpCode == OP_SLTIU) ||
                        is_andi || is_lui;
    assign is_shift   = is_r && ((Funct == FN_SLL) || (Funct == FN_SRL) ||
                                 (Funct == FN_SRA));
    assign is_jump    = is_j || is_jal || is_jr || is_jalr;
    assign supported  = is_r || is_j || is_jal || is_beq || is_alu_imm ||
                        is_lw || is_sw;

    // ALU operation for the immediate-ALU group.
    always_comb begin
        imm_alu_op = ALU_ADD;
        case (OpCode)
            OP_ADDIU: imm_alu_op = ALU_ADDU;
            OP_SLTI:  imm_alu_op = ALU_SLT;
            OP_SLTIU: imm_alu_op = ALU_SLTU;
            OP_ANDI:  imm_alu_op = ALU_AND;
            default:  imm_alu_op = ALU_ADD;
        endcase
    end

    // State register; reset aborts any instruction and parks in IF.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IF;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = S_IF;
        case (state)
            S_IF:  next_state = mem_ok ? S_ID : S_IF;
            S_ID:  next_state = (is_jump || !supported) ? S_IF : S_EX;
            S_EX: begin
                if (is_lw || is_sw) begin
                    next_state = S_MEM;
                end else if (is_beq) begin
                    next_state = S_IF;
                end else begin
                    next_state = S_WB;
                end
            end
            S_MEM: begin
                if (!mem_ok) begin
                    next_state = S_MEM;
                end else begin
                    next_state = is_lw ? S_WB : S_IF;
                end
            end
            S_WB:    next_state = S_IF;
            default: next_state = S_IF;
        endcase
    end

    // Moore output decode; write strobes are forced low while in reset.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = DST_RT;
        MemtoReg    = WB_ALUOUT;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_REG;
        ALUOp       = ALU_ADD;
        PCSource    = PCS_ALU;
        ExtOp       = 1'b0;
        LuiOp       = 1'b0;
        case (state)
            S_IF: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                PCWrite = mem_ok;
                IRWrite = mem_ok;
            end
            S_ID: begin
                // Branch target is always computed into ALUOut here.
                ALUSrcB = SRCB_BR;
                ExtOp   = 1'b1;
                if (is_j || is_jal) begin
                    PCSource = PCS_JUMP;
                    PCWrite  = 1'b1;
                end
                if (is_jr || is_jalr) begin
                    PCSource = PCS_REGA;
                    PCWrite  = 1'b1;
                end
                if (is_jal) begin
                    RegWrite = 1'b1;
                    RegDst   = DST_RA;
                    MemtoReg = WB_PC;
                end
                if (is_jalr) begin
                    RegWrite = 1'b1;
                    RegDst   = DST_RD;
                    MemtoReg = WB_PC;
                end
            end
            S_EX: begin
                if (is_r) begin
                    ALUSrcA = is_shift ? SRCA_SHAMT : SRCA_REG;
                    ALUSrcB = SRCB_REG;
                    ALUOp   = ALU_RTYPE;
                end else if (is_alu_imm) begin
                    ALUSrcA = SRCA_REG;
                    ALUSrcB = SRCB_IMM;
                    ALUOp   = imm_alu_op;
                    ExtOp   = !is_andi;
                    LuiOp   = is_lui;
                end else if (is_lw || is_sw) begin
                    ALUSrcA = SRCA_REG;
                    ALUSrcB = SRCB_IMM;
                    ALUOp   = ALU_ADD;
                    ExtOp   = 1'b1;
                end else if (is_beq) begin
                    ALUSrcA     = SRCA_REG;
                    ALUSrcB     = SRCB_REG;
                    ALUOp       = ALU_SUB;
                    PCWriteCond = 1'b1;
                    PCSource    = PCS_ALUOUT;
                end
            end
            S_MEM: begin
                IorD     = 1'b1;
                MemRead  = is_lw;
                MemWrite = is_sw && mem_ok;
            end
            S_WB: begin
                RegWrite = 1'b1;
                RegDst   = is_r ? DST_RD : DST_RT;
                MemtoReg = is_lw ? WB_MDR : WB_ALUOUT;
            end
            default: begin
            end
        endcase
        if (!reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
            MemWrite    = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle expected control words
// are queued per instruction and compared as the FSM steps through them.
// Honours MEM_WAIT_EN when the design is built with it.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic [1:0] pc_source;
        logic       ext_op;
        logic       lui_op;
        logic [2:0] state;
    } ctl_t;

    typedef struct {
        ctl_t       exp;
        logic [5:0] op;
        logic [5:0] fn;
        logic       rdy;
        string      tag;
    } item_t;

    logic       clk;
    logic       reset;
    logic [5:0] OpCode;
    logic [5:0] Funct;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite;
    logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource;
    logic [3:0] ALUOp;
    logic       ExtOp, LuiOp;
    logic [2:0] State;

    ctl_t  obs;
    item_t q[$];
    int    total = 0;
    int    bad   = 0;

    multicycle_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .OpCode      (OpCode),
        .Funct       (Funct),
        .MemReady    (MemReady),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .MemtoReg    (MemtoReg),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .ExtOp       (ExtOp),
        .LuiOp       (LuiOp),
        .State       (State)
    );

    assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
                  RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource, ExtOp, LuiOp,
                  State};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    function automatic ctl_t f_if();
        ctl_t e;
        e           = '0;
        e.mem_read  = 1'b1;
        e.ir_write  = 1'b1;
        e.alu_src_b = 2'b01;
        e.pc_write  = 1'b1;
        return e;
    endfunction

    function automatic ctl_t f_rst();
        ctl_t e;
        e          = f_if();
        e.pc_write = 1'b0;
        e.ir_write = 1'b0;
        return e;
    endfunction

    function automatic ctl_t f_id();
        ctl_t e;
        e           = '0;
        e.state     = 3'd1;
        e.alu_src_b = 2'b11;
        e.ext_op    = 1'b1;
        return e;
    endfunction

    task automatic check(input ctl_t exp, input string tag);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input ctl_t e, input logic [5:0] op, input logic [5:0] fn,
                        input logic rdy, input string tag);
        item_t it;
        it.exp = e;
        it.op  = op;
        it.fn  = fn;
        it.rdy = rdy;
        it.tag = tag;
        q.push_back(it);
    endtask

    // Expected per-cycle control words for one instruction, IF through retirement.
    task automatic push_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                              input int if_wait, input int mem_wait);
        ctl_t e;
        ctl_t w;
        e = f_if();
`ifdef MEM_WAIT_EN
        for (int i = 0; i < if_wait; i++) begin
            w          = e;
            w.pc_write = 1'b0;
            w.ir_write = 1'b0;
            push(w, op, fn, 1'b0, {nm, ".IF-wait"});
        end
        push(e, op, fn, 1'b1, {nm, ".IF"});
`else
        push(e, op, fn, (if_wait == 0), {nm, ".IF"});
`endif
        e = f_id();
        case (op)
            6'h02, 6'h03: begin
                e.pc_source = 2'b10;
                e.pc_write  = 1'b1;
                if (op == 6'h03) begin
                    e.reg_write  = 1'b1;
                    e.reg_dst    = 2'b10;
                    e.mem_to_reg = 2'b10;
                end
                push(e, op, fn, 1'b1, {nm, ".ID"});
            end
            6'h00: begin
                if (fn == 6'h08 || fn == 6'h09) begin
                    e.pc_source = 2'b11;
                    e.pc_write  = 1'b1;
                    if (fn == 6'h09) begin
                        e.reg_write  = 1'b1;
                        e.reg_dst    = 2'b01;
                        e.mem_to_reg = 2'b10;
                    end
                    push(e, op, fn, 1'b1, {nm, ".ID"});
                end else begin
                    push(e, op, fn, 1'b1, {nm, ".ID"});
                    e           = '0;
                    e.state     = 3'd2;
                    e.alu_src_a = (fn == 6'h00 || fn == 6'h02 || fn == 6'h03) ? 2'b10 : 2'b01;
                    e.alu_op    = 4'b0010;
                    push(e, op, fn, 1'b1, {nm, ".EX"});
                    e           = '0;
                    e.state     = 3'd4;
                    e.reg_write = 1'b1;
                    e.reg_dst   = 2'b01;
                    push(e, op, fn, 1'b1, {nm, ".WB"});
                end
            end
            6'h04: begin
                push(e, op, fn, 1'b1, {nm, ".ID"});
                e               = '0;
                e.state         = 3'd2;
                e.alu_src_a     = 2'b01;
                e.alu_op        = 4'b0001;
                e.pc_write_cond = 1'b1;
                e.pc_source     = 2'b01;
                push(e, op, fn, 1'b1, {nm, ".EX"});
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0F: begin
                push(e, op, fn, 1'b1, {nm, ".ID"});
                e           = '0;
                e.state     = 3'd2;
                e.alu_src_a = 2'b01;
                e.alu_src_b = 2'b10;
                e.ext_op    = (op != 6'h0C);
                e.lui_op    = (op == 6'h0F);
                case (op)
                    6'h09:   e.alu_op = 4'b1000;
                    6'h0A:   e.alu_op = 4'b0101;
                    6'h0B:   e.alu_op = 4'b1101;
                    6'h0C:   e.alu_op = 4'b0100;
                    default: e.alu_op = 4'b0000;
                endcase
                push(e, op, fn, 1'b1, {nm, ".EX"});
                e           = '0;
                e.state     = 3'd4;
                e.reg_write = 1'b1;
                push(e, op, fn, 1'b1, {nm, ".WB"});
            end
            6'h23, 6'h2B: begin
                push(e, op, fn, 1'b1, {nm, ".ID"});
                e           = '0;
                e.state     = 3'd2;
                e.alu_src_a = 2'b01;
                e.alu_src_b = 2'b10;
                e.ext_op    = 1'b1;
                push(e, op, fn, 1'b1, {nm, ".EX"});
                e       = '0;
                e.state = 3'd3;
                e.iord  = 1'b1;
                if (op == 6'h23) e.mem_read = 1'b1;
                else             e.mem_write = 1'b1;
`ifdef MEM_WAIT_EN
                for (int i = 0; i < mem_wait; i++) begin
                    w           = e;
                    w.mem_write = 1'b0;
                    push(w, op, fn, 1'b0, {nm, ".MEM-wait"});
                end
                push(e, op, fn, 1'b1, {nm, ".MEM"});
`else
                push(e, op, fn, (mem_wait == 0), {nm, ".MEM"});
`endif
                if (op == 6'h23) begin
                    e            = '0;
                    e.state      = 3'd4;
                    e.reg_write  = 1'b1;
                    e.mem_to_reg = 2'b01;
                    push(e, op, fn, 1'b1, {nm, ".WB"});
                end
            end
            default: push(e, op, fn, 1'b1, {nm, ".ID-nop"});
        endcase
    endtask

    // Pop up to n expected cycles, driving each cycle's inputs at the falling edge.
    task automatic run_n(input int n);
        item_t it;
        for (int i = 0; i < n && q.size() > 0; i++) begin
            it = q.pop_front();
            @(negedge clk);
            OpCode   = it.op;
            Funct    = it.fn;
            MemReady = it.rdy;
            #1;
            check(it.exp, it.tag);
        end
    endtask

    task automatic run_all();
        run_n(q.size());
    endtask

    task automatic do_instr(input string nm, input logic [5:0] op, input logic [5:0] fn);
        push_instr(nm, op, fn, 0, 0);
        run_all();
    endtask

    initial begin
        reset    = 1'b0;
        OpCode   = 6'h00;
        Funct    = 6'h00;
        MemReady = 1'b1;
        #2;
        check(f_rst(), "reset.hold0");
        @(negedge clk);
        #1;
        check(f_rst(), "reset.hold1");
        @(posedge clk);
        #2;
        reset = 1'b1;

        do_instr("addu",  6'h00, 6'h21);
        do_instr("sll",   6'h00, 6'h00);
        do_instr("sra",   6'h00, 6'h03);
        do_instr("lw",    6'h23, 6'h00);
        do_instr("sw",    6'h2B, 6'h00);
        do_instr("beq",   6'h04, 6'h00);
        do_instr("jal",   6'h03, 6'h00);
        do_instr("j",     6'h02, 6'h00);
        do_instr("jr",    6'h00, 6'h08);
        do_instr("jalr",  6'h00, 6'h09);
        do_instr("addi",  6'h08, 6'h00);
        do_instr("addiu", 6'h09, 6'h00);
        do_instr("slti",  6'h0A, 6'h00);
        do_instr("sltiu", 6'h0B, 6'h00);
        do_instr("andi",  6'h0C, 6'h00);
        do_instr("lui",   6'h0F, 6'h00);
        do_instr("nop3f", 6'h3F, 6'h00);
        do_instr("nop05", 6'h05, 6'h00);

        // MemReady low: stalls with MEM_WAIT_EN, ignored otherwise.
        push_instr("lw.stall", 6'h23, 6'h00, 0, 3);
        run_all();
        push_instr("sw.stall", 6'h2B, 6'h00, 2, 1);
        run_all();

        // Reset during EX of sw aborts it before any memory write.
        push_instr("sw.abort", 6'h2B, 6'h00, 0, 0);
        run_n(3);
        #1;
        reset = 1'b0;
        #1;
        check(f_rst(), "abort.reset0");
        @(negedge clk);
        #1;
        check(f_rst(), "abort.reset1");
        q.delete();
        @(posedge clk);
        #2;
        reset = 1'b1;
        do_instr("post.addu", 6'h00, 6'h21);
        do_instr("post.beq",  6'h04, 6'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
